// File: rtl/regfile_param_bypass.sv
// rtl/regfile_param_bypass.sv - parametrised register file with post-reset clear sequencer and write-to-read bypass
module regfile_param_bypass #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int NUM_RD       = 2,
  parameter bit BYPASS       = 1'b1,
  parameter bit CLEAR_ON_RST = 1'b1,
  parameter bit ZERO_REG     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        write_add,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*ADDR_W-1:0] read_add,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic                     ready
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RST_STATE = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic                wr_fire;
  logic [ADDR_W-1:0]   rd_addr;

  // A write only lands when the file is ready; register 0 swallows writes when hardwired
  assign wr_fire = ready_q && RegWrite && !(ZERO_REG && (write_add == '0));
  assign ready   = ready_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    regs_d    = regs_q;
    case (state_q)
      ST_CLEAR: begin
        regs_d[clr_cnt_q[ADDR_W-1:0]] = '0;
        clr_cnt_d = clr_cnt_q + (ADDR_W+1)'(1);
        if (clr_cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
        if (wr_fire) begin
          regs_d[write_add] = write_data;
        end
      end
    endcase
  end

  // Reset leaves the array untouched; only the sequencer or a write changes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      regs_q    <= regs_d;
    end
  end

  always_comb begin
    read_data = '0;
    rd_addr   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr = read_add[i*ADDR_W +: ADDR_W];
      if (rst || !ready_q) begin
        read_data[i*DATA_W +: DATA_W] = '0;
      end else if (ZERO_REG && (rd_addr == '0)) begin
        read_data[i*DATA_W +: DATA_W] = '0;
      end else if (BYPASS && wr_fire && (write_add == rd_addr)) begin
        read_data[i*DATA_W +: DATA_W] = write_data;
      end else begin
        read_data[i*DATA_W +: DATA_W] = regs_q[rd_addr];
      end
    end
  end

endmodule
